outport: RTL
============

// Module: outport
// PURPOSE
//  Output port of the router; the transmit end of the inter-router link that inport receives.
//  Registers the flit granted through the crossbar and drives it onto the 48-bit channel.
//  Signals each launched flit by toggling a complementary flow-control pair.
//  Tracks downstream input-buffer space with a credit counter refilled by toggles on the return pair.
//  Tells the arbiter when a grant is allowed.
// PARAMETERS
//  CREDITS     4   downstream buffer depth in flits = initial and maximum credit count (1..15)
//  FLIT_WIDTH  48  channel width in bits; [47:44]=X dest, [43:40]=Y dest (passed through unchanged)
// PORTS
//  clka            in   1           clock, all state on rising edge
//  rsta            in   1           asynchronous reset, active-low
//  crossbar_din    in   FLIT_WIDTH  flit from crossbar, qualified by grant_din
//  grant_din       in   1           arbiter grant: launch crossbar_din this cycle
//  diff_pair_din   in   2           credit-return pair from downstream {p,n}
//  ready_dout      out  1           credit available; arbiter may assert grant_din
//  channel_dout    out  FLIT_WIDTH  registered flit to downstream inport
//  diff_pair_dout  out  2           flit-strobe pair to downstream {p,n}
//  credit_dout     out  4           current credit count (debug/arbiter priority)
//  error_dout      out  1           sticky protocol error flag
// BEHAVIOUR
//  Reset (rsta=0, async):
//   - channel_dout=0; tx_tog=0, so diff_pair_dout=2'b01.
//   - credit_cnt=CREDITS; cred_last=0; error_dout=0; ready_dout=1.
//  Pair encoding, both directions:
//   - Valid code: p != n. p toggling between valid codes = one event.
//   - diff_pair_dout is always {tx_tog, ~tx_tog}.
//  Launch:
//   - Occurs when grant_din=1 and credit_cnt!=0 in cycle N.
//   - Edge ending N: channel_dout<=crossbar_din, tx_tog flips, credit_cnt decrements.
//   - Visible cycle N+1: latency 1.
//   - channel_dout holds the last flit until the next launch.
//  Back-to-back grants:
//   - One flit per cycle while credits remain.
//   - Each launch flips tx_tog, so the downstream sees one toggle per flit.
//  ready_dout:
//   - Combinational (credit_cnt != 0).
//   - Reflects the count after the previous edge. No same-cycle credit bypass.
//  Grant with credit_cnt=0:
//   - Flit dropped; no toggle; count stays 0.
//   - error_dout<=1.
//  Credit return:
//   - Comparison is combinational each cycle.
//   - Credit event when diff_pair_din is a valid code and diff_pair_din[1] != cred_last.
//   - On an event: cred_last<=diff_pair_din[1] and credit_cnt increments at that edge.
//  Invalid return code (p==n):
//   - Ignored; cred_last held.
//   - error_dout<=1.
//  Simultaneous launch and credit event in one cycle:
//   - credit_cnt unchanged. Flit still launched and cred_last updated.
//  Credit event with credit_cnt==CREDITS and no launch (overflow):
//   - Count saturates at CREDITS.
//   - error_dout<=1.
//  error_dout is cleared only by reset.
//  Reset mid-operation:
//   - All state returns to reset values immediately (async).
//   - An in-flight flit is lost; both link ends must reset together.
//  Arithmetic: credit_cnt is 4-bit unsigned; never wraps below 0 or above CREDITS.
// TESTING
//  1. Reset release, no grants -> diff_pair_dout=2'b01, credit_dout=4, ready_dout=1, error_dout=0, channel_dout=0.
//  2. Grant 48'hA5_0000_0000_01 at N -> cycle N+1 channel_dout=48'hA5_0000_0000_01, diff_pair_dout=2'b10, credit_dout=3.
//  3. 5 consecutive grants, no returns -> 4 launches (toggles 10,01,10,01); credit_dout=0, ready_dout=0; 5th dropped, error_dout=1.
//  4. From credit 0, flip diff_pair_din 01->10 -> next cycle credit_dout=1, ready_dout=1. Grant + flip 10->01 in the same cycle -> credit stays 1.
//  5. diff_pair_din=2'b11 for one cycle at credit 4 -> credit_dout unchanged, error_dout=1. Valid toggle at credit 4 -> stays 4, error_dout=1.
//  6. Assert rsta low mid-burst (credit 2) -> same cycle credit_dout=4, diff_pair_dout=2'b01, error_dout=0, channel_dout=0.

Source files
------------

// File: rtl/outport_if.sv
// Link-side bundle of the router output port: crossbar flit/grant in, channel, strobe pair and status out.
// The slave modport is the outport itself; the master modport is the router/testbench side.
interface outport_if #(
    parameter int FLIT_WIDTH = 48
);
    logic [FLIT_WIDTH-1:0] crossbar_din;
    logic                  grant_din;
    logic [1:0]            diff_pair_din;
    logic                  ready_dout;
    logic [FLIT_WIDTH-1:0] channel_dout;
    logic [1:0]            diff_pair_dout;
    logic [3:0]            credit_dout;
    logic                  error_dout;

    modport slave (
        input  crossbar_din,
        input  grant_din,
        input  diff_pair_din,
        output ready_dout,
        output channel_dout,
        output diff_pair_dout,
        output credit_dout,
        output error_dout
    );

    modport master (
        output crossbar_din,
        output grant_din,
        output diff_pair_din,
        input  ready_dout,
        input  channel_dout,
        input  diff_pair_dout,
        input  credit_dout,
        input  error_dout
    );
endinterface

// File: rtl/outport.sv
// Router output port: registers each granted flit onto the link (1-cycle latency) and toggles the strobe pair.
// Backpressure: ready_dout drops at zero credits; a grant then drops the flit and sets the sticky error flag.
module outport #(
    parameter int CREDITS    = 4,
    parameter int FLIT_WIDTH = 48
) (
    input  logic      clka,
    input  logic      rsta,
    outport_if.slave  port
);
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    logic [FLIT_WIDTH-1:0] chan_q,      chan_d;
    logic                  tx_tog_q,    tx_tog_d;
    logic [3:0]            credit_q,    credit_d;
    logic                  cred_last_q, cred_last_d;
    logic                  err_q,       err_d;

    logic launch;
    logic drop;
    logic ret_valid;
    logic cred_evt;
    logic overflow;

    always_comb begin
        launch    = port.grant_din && (credit_q != 4'd0);
        drop      = port.grant_din && (credit_q == 4'd0);
        ret_valid = port.diff_pair_din[1] != port.diff_pair_din[0];
        cred_evt  = ret_valid && (port.diff_pair_din[1] != cred_last_q);
        overflow  = cred_evt && !launch && (credit_q == CRED_MAX);
    end

    always_comb begin
        chan_d      = chan_q;
        tx_tog_d    = tx_tog_q;
        credit_d    = credit_q;
        cred_last_d = cred_last_q;
        err_d       = err_q;

        if (launch) begin
            chan_d   = port.crossbar_din;
            tx_tog_d = ~tx_tog_q;
        end

        if (cred_evt) begin
            cred_last_d = port.diff_pair_din[1];
        end

        // A launch and a returned credit in the same cycle cancel out.
        if (launch && !cred_evt) begin
            credit_d = credit_q - 4'd1;
        end else if (cred_evt && !launch && !overflow) begin
            credit_d = credit_q + 4'd1;
        end

        if (drop || !ret_valid || overflow) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            chan_q      <= '0;
            tx_tog_q    <= 1'b0;
            credit_q    <= CRED_MAX;
            cred_last_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            chan_q      <= chan_d;
            tx_tog_q    <= tx_tog_d;
            credit_q    <= credit_d;
            cred_last_q <= cred_last_d;
            err_q       <= err_d;
        end
    end

    assign port.channel_dout   = chan_q;
    assign port.diff_pair_dout = {tx_tog_q, ~tx_tog_q};
    assign port.credit_dout    = credit_q;
    assign port.ready_dout     = (credit_q != 4'd0);
    assign port.error_dout     = err_q;
endmodule
